shifter_seq: RTL and testbench

Iterative 32-bit shift sequencer that drives the ALU's single-stage conditional shifter slices. It accepts an operand, shift amount and shift kind over a valid/ready handshake. It then applies one power-of-two stage per clock (16, 8, 4, 2, 1) on an internal working register and presents the result over a second valid/ready handshake. It sits between the ALU operand/control path and the ALU result mux. It replaces the purely combinational five-stage chain where a registered, multi-cycle shift is required.

---
 rtl/shifter_pkg.sv | 21 ++
 rtl/shift_stage_mux.sv | 18 +
 rtl/shifter_seq.sv | 90 +++++++++
 tb/tb_shifter_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared constants and encodings for the iterative shift sequencer.
// Imported by shifter_seq and shift_stage_mux.
package shifter_pkg;

    localparam int WIDTH  = 32;
    localparam int STAGES = 5;

    typedef enum logic [1:0] {
        SH_SRL = 2'b00,
        SH_SLL = 2'b01,
        SH_SRA = 2'b10,
        SH_RSV = 2'b11
    } sh_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_stage_mux.sv
// One conditional right-shift slice: shifts by DIST with a fill bit when en is set,
// otherwise passes the input through.
module shift_stage_mux
    import shifter_pkg::*;
#(
    parameter int DIST = 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             fill,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = en ? {{DIST{fill}}, in[WIDTH-1:DIST]} : in;
    end

endmodule

// File: rtl/shifter_seq.sv
// Iterative 32-bit shifter: one power-of-two stage per clock (16, 8, 4, 2, 1),
// valid/ready handshakes on the request and result sides.
module shifter_seq
    import shifter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [4:0]       in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam logic [2:0] K_FIRST = 3'(STAGES - 1);

    state_e            state;
    state_e            state_nxt;
    logic [2:0]        k;
    logic [WIDTH-1:0]  w;
    logic              fill;
    sh_op_e            op_q;
    logic [STAGES-1:0] shamt_q;
    logic [WIDTH-1:0]  stage_out [STAGES];
    logic              accept;

    // SLL is done as reverse / right-shift / reverse, so only right stages exist.
    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        shift_stage_mux #(.DIST(1 << i)) u_stage (
            .in   (w),
            .en   (shamt_q[i]),
            .fill (fill),
            .out  (stage_out[i])
        );
    end

    assign accept = (state == IDLE) && in_valid;

    // NOTE: state register uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: default assigned first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (k == 3'd0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= K_FIRST;
            w       <= '0;
            fill    <= 1'b0;
            op_q    <= SH_SRL;
            shamt_q <= '0;
        end else if (accept) begin
            k       <= K_FIRST;
            shamt_q <= in_shamt;
            op_q    <= sh_op_e'(in_op);
            w       <= (in_op == SH_SLL) ? bit_rev(in_data) : in_data;
            fill    <= (in_op == SH_SRA) && in_data[WIDTH-1];
        end else if (state == SHIFT) begin
            w <= stage_out[k];
            k <= (k == 3'd0) ? K_FIRST : k - 3'd1;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = (state != DONE) ? '0 : (op_q == SH_SLL) ? bit_rev(w) : w;

endmodule

// File: tb/tb_shifter_seq.sv
// Directed self-checking bench for shifter_seq: all ops, latency, backpressure
// and asynchronous reset abort.
module tb_shifter_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    shifter_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request once in_ready is up; returns #1 after the accept edge.
    task automatic start(input logic [1:0] op, input logic [31:0] data, input logic [4:0] shamt);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_req", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        in_shamt = shamt;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles to out_valid (bounded) and check latency and result.
    task automatic wait_result(input string tag, input logic [31:0] exp);
        int cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'd5);
        check({tag, "_data"}, out_data, exp);
    endtask

    task automatic finish_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] data,
                       input logic [4:0] shamt, input logic [31:0] exp);
        start(op, data, shamt);
        wait_result(tag, exp);
        finish_result();
    endtask

    initial begin
        logic seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = 2'b00;
        out_ready = 1'b0;

        #3;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_data",  out_data,       32'h0);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        run("srl_4",      2'b00, 32'h8000_0000, 5'd4,  32'h0800_0000);
        run("sra_4",      2'b10, 32'h8000_00F0, 5'd4,  32'hF800_000F);
        run("sra_31",     2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
        run("sra_31_neg", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run("sll_31",     2'b01, 32'h0000_0001, 5'd31, 32'h8000_0000);
        run("sll_8",      2'b01, 32'h1234_5678, 5'd8,  32'h3456_7800);
        run("rsv_4",      2'b11, 32'hF000_0000, 5'd4,  32'h0F00_0000);
        run("srl_0",      2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        run("sll_0",      2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        run("sra_0",      2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        run("rsv_0",      2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);

        // Backpressure: result held in DONE, a stray request ignored.
        start(2'b00, 32'h00FF_0000, 5'd8);
        wait_result("bp", 32'h0000_FF00);
        for (int c = 0; c < 3; c++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  out_data,       32'h0000_FF00);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            if (c == 1) begin
                in_valid = 1'b1;
                in_op    = 2'b01;
                in_data  = 32'h1111_1111;
                in_shamt = 5'd3;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        check("bp_out_data_after", out_data, 32'h0000_FF00);
        finish_result();
        check("bp_in_ready_after", 32'(in_ready),  32'd1);
        check("bp_valid_after",    32'(out_valid), 32'd0);
        check("bp_data_after",     out_data,       32'h0);
        run("b2b_sll_4", 2'b01, 32'h0000_0001, 5'd4, 32'h0000_0010);

        // Reset asserted mid-SHIFT with k=2 (two stage edges after accept).
        start(2'b10, 32'hAAAA_AAAA, 5'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_out_data",  out_data,       32'h0);
        #13 rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("post_rst_no_valid", 32'(seen_valid), 32'd0);
        check("post_rst_in_ready", 32'(in_ready),   32'd1);
        run("post_rst_srl_1", 2'b00, 32'hFFFF_FFFF, 5'd1, 32'h7FFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
